// File: rtl/serial_comp_pkg.sv
// ---------------------------------------------------------------------------
// serial_comp_pkg
//   Shared types and constants for the bit-serial comparison controller.
//   - state_t  : controller FSM states
//   - result_t : one-hot comparison result {lt, gt, eq}
//   - MAX_WIDTH: largest operand width the controller is intended for
// ---------------------------------------------------------------------------
package serial_comp_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
    } result_t;

    localparam result_t RES_NONE = '{lt: 1'b0, gt: 1'b0, eq: 1'b0};
    localparam result_t RES_EQ   = '{lt: 1'b0, gt: 1'b0, eq: 1'b1};

    // Result for a bit position that differs, taken from the slice outputs.
    function automatic result_t res_from_slice(input logic lt_bit, input logic gt_bit);
        result_t r;
        r.lt = lt_bit;
        r.gt = gt_bit;
        r.eq = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/compare_1_bit.sv
// ---------------------------------------------------------------------------
// compare_1_bit
//   Single-bit magnitude comparator slice, purely combinational.
//   Ports:
//     i_a  : bit of operand A
//     i_b  : bit of operand B
//     o_lt : A bit < B bit
//     o_gt : A bit > B bit
//     o_eq : bits equal
// ---------------------------------------------------------------------------
module compare_1_bit (
    input  logic i_a,
    input  logic i_b,
    output logic o_lt,
    output logic o_gt,
    output logic o_eq
);

    assign o_lt = ~i_a &  i_b;
    assign o_gt =  i_a & ~i_b;
    assign o_eq = ~(i_a ^ i_b);

endmodule

// File: rtl/serial_comp_ctrl.sv
// ---------------------------------------------------------------------------
// serial_comp_ctrl
//   Bit-serial magnitude comparator controller. Accepts an operand pair over
//   a valid/ready handshake, scans MSB to LSB one bit per cycle through a
//   single compare_1_bit slice, stops at the first differing bit and returns
//   a one-hot lt/gt/eq result plus the index of the deciding bit.
//
//   state | meaning
//   IDLE  | ready for an operand pair (o_in_ready=1)
//   SCAN  | comparing op_a[idx] vs op_b[idx], idx counting down (o_busy=1)
//   DONE  | result held on outputs until i_out_ready (o_out_valid=1)
//
//   Ports:
//     i_clk        : rising-edge clock
//     i_rst_n      : asynchronous active-low reset
//     i_in_valid   : operand pair presented
//     o_in_ready   : controller can accept a pair (decoded from state)
//     i_a, i_b     : operands, sampled on accept
//     o_out_valid  : result available (decoded from state)
//     i_out_ready  : consumer takes the result
//     o_lt/o_gt/o_eq : registered one-hot result
//     o_diff_idx   : registered index of deciding bit, 0 when equal
//     o_busy       : high while scanning (decoded from state)
// ---------------------------------------------------------------------------
module serial_comp_ctrl
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_lt,
    output logic             o_gt,
    output logic             o_eq,
    output logic [IDXW-1:0]  o_diff_idx,
    output logic             o_busy
);

    localparam logic [IDXW-1:0] IDX_MSB = IDXW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [IDXW-1:0]  r_idx;
    result_t          r_res;
    logic [IDXW-1:0]  r_diff_idx;

    logic w_bit_a;
    logic w_bit_b;
    logic w_lt;
    logic w_gt;
    logic w_eq;

    // Bit-select muxes feeding the single shared slice.
    assign w_bit_a = r_op_a[r_idx];
    assign w_bit_b = r_op_b[r_idx];

    compare_1_bit u_cmp (
        .i_a  (w_bit_a),
        .i_b  (w_bit_b),
        .o_lt (w_lt),
        .o_gt (w_gt),
        .o_eq (w_eq)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_idx      <= IDX_MSB;
            r_res      <= RES_NONE;
            r_diff_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_op_a     <= i_a;
                        r_op_b     <= i_b;
                        r_idx      <= IDX_MSB;
                        r_res      <= RES_NONE;
                        r_diff_idx <= '0;
                        r_state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!w_eq) begin
                        r_res      <= res_from_slice(w_lt, w_gt);
                        r_diff_idx <= r_idx;
                        r_state    <= ST_DONE;
                    end else if (r_idx == '0) begin
                        r_res      <= RES_EQ;
                        r_diff_idx <= '0;
                        r_state    <= ST_DONE;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                ST_DONE: begin
                    // Clearing on release keeps lt/gt/eq at 0 outside DONE.
                    if (i_out_ready) begin
                        r_res      <= RES_NONE;
                        r_diff_idx <= '0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_res      <= RES_NONE;
                    r_diff_idx <= '0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_busy      = (r_state == ST_SCAN);
    assign o_lt        = r_res.lt;
    assign o_gt        = r_res.gt;
    assign o_eq        = r_res.eq;
    assign o_diff_idx  = r_diff_idx;

endmodule

// File: doc/serial_comp_ctrl.md
# serial_comp_ctrl

Sequencing controller for bit-serial magnitude comparison of two WIDTH-bit operands using a single shared `compare_1_bit` slice instead of a WIDTH-wide comparator array. It accepts an operand pair over a valid/ready handshake and scans from MSB to LSB, one bit per cycle. It stops at the first differing bit and returns a one-hot less/greater/equal result plus the index of the deciding bit over a second valid/ready handshake. It sits between an operand producer (e.g. a sort or search engine) and any consumer of comparison results.

## Interface
- WIDTH, default 8: operand width; legal range 2..64.
- IDXW, default $clog2(WIDTH): width of the bit-index field.

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- in_valid  in  1  operand pair presented
- in_ready  out  1  controller can accept an operand pair
- a  in  WIDTH  operand A, sampled on accept
- b  in  WIDTH  operand B, sampled on accept
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- lt  out  1  A < B
- gt  out  1  A > B
- eq  out  1  A == B
- diff_idx  out  IDXW  index of the deciding (first differing) bit; 0 when eq
- busy  out  1  high while in SCAN

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: capture a and b into op_a and op_b, set idx=WIDTH-1, clear lt/gt/eq/diff_idx, then go to SCAN.
- **SCAN**
  - in_ready=0, busy=1.
  - The `compare_1_bit` slice sees op_a[idx] and op_b[idx] combinationally.
  - Mismatch: register lt or gt from the slice, set diff_idx=idx, go to DONE.
  - Match with idx==0: set eq=1, diff_idx=0, go to DONE.
  - Match with idx>0: decrement idx and stay in SCAN.
- **DONE**
  - out_valid=1; lt, gt, eq and diff_idx are held stable.
  - On out_ready: go to IDLE.
  - Only one operand pair is in flight at a time; no accept occurs in the same cycle as result release.
- **Result encoding:** while out_valid=1, exactly one of lt/gt/eq is 1. In IDLE and SCAN all three are 0.
- **Operand handling:** a and b may change freely after the accept cycle; only op_a and op_b are used.
- **Index arithmetic:** idx is an unsigned IDXW-bit down-counter. It never decrements below 0, because SCAN exits at idx==0.
- **Handshake protocol:** in_valid and out_ready are not required to stay high. A dropped in_valid in IDLE means no accept.

## Timing
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, lt=gt=eq=0, diff_idx=0, busy=0, idx=WIDTH-1.
- **Reset behaviour:** takes effect immediately, mid-SCAN or mid-DONE. Any pending result is discarded.
- **Latency:** with accept in cycle 0 and the first differing bit at k, out_valid rises at cycle WIDTH-k.
  - Best case, MSB differs: 1 cycle after accept.
  - Equal operands: WIDTH cycles after accept.
- **Throughput:** at most one comparison per (latency + 1) cycles, because the release cycle returns to IDLE.
- **DONE with out_ready already high:** out_valid is high for exactly one cycle.
- **Registered outputs:** all outputs are registered except in_ready, out_valid and busy, which decode directly from the state register (glitch-free).

## Structure
- Package `serial_comp_pkg` holds:
  - the state enum (IDLE, SCAN, DONE);
  - a result struct {lt, gt, eq};
  - the constant for the maximum WIDTH.
- One sub-module: the existing `compare_1_bit`, instantiated once and driven by the bit-select muxes on op_a/op_b.
- The FSM, index counter and result registers live in the top module.

## Test plan
- **Reset state:** reset asserted, then released → in_ready=1, out_valid=0, lt/gt/eq=0.
- **MSB differs:** a=8'h80, b=8'h7F, out_ready=1 → out_valid 1 cycle after accept; gt=1, diff_idx=7, out_valid high 1 cycle.
- **LSB differs:** a=8'h12, b=8'h13 → out_valid 8 cycles after accept; lt=1, diff_idx=0.
- **Equal and back-pressure:** a=b=8'hA5, out_ready held 0 for 5 cycles → eq=1, diff_idx=0.
  - out_valid and the result stay stable until out_ready.
  - in_ready stays 0 throughout.
- **Input hold and mid-scan reset:**
  - a=8'h40, b=8'h00: change a to 8'h00 one cycle after accept → gt=1, diff_idx=6.
  - Then start a=8'h01, b=8'h03 and assert rst_n low 3 cycles after accept → immediate IDLE, out_valid never rises, next accept works.
- **Randomized back-to-back:** 1000 random pairs with random in_valid/out_ready → every result matches a scoreboard.
  - The scoreboard checks lt/gt/eq and diff_idx = MSB index of a^b.
  - Every latency equals WIDTH-diff_idx.
